// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types, bit map and helpers for the SECDED receiver
package hamming_pkg;

    localparam int IDX_P1  = 0;
    localparam int IDX_P2  = 1;
    localparam int IDX_D0  = 2;
    localparam int IDX_P4  = 3;
    localparam int IDX_D1  = 4;
    localparam int IDX_D2  = 5;
    localparam int IDX_D3  = 6;
    localparam int IDX_PAR = 7;

    typedef logic [7:0] codeword_t;
    typedef logic [2:0] syndrome_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        NONE,
        CORRECTED,
        UNCORRECTABLE
    } err_class_e;

    // {s4,s2,s1}: each bit covers the positions whose 1-based index has that bit set
    function automatic syndrome_t calc_syndrome(input codeword_t cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[IDX_P1] ^ cw[IDX_D0] ^ cw[IDX_D1] ^ cw[IDX_D3];
        s2 = cw[IDX_P2] ^ cw[IDX_D0] ^ cw[IDX_D2] ^ cw[IDX_D3];
        s4 = cw[IDX_P4] ^ cw[IDX_D1] ^ cw[IDX_D2] ^ cw[IDX_D3];
        return {s4, s2, s1};
    endfunction

    // Overall parity across all eight bits; 1 means an odd number of flips
    function automatic logic calc_parity(input codeword_t cw);
        return ^cw;
    endfunction

    function automatic nibble_t extract_data(input codeword_t cw);
        return {cw[IDX_D3], cw[IDX_D2], cw[IDX_D1], cw[IDX_D0]};
    endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// rtl/hamming_secded_core.sv - combinational SECDED decode and single-bit correction
module hamming_secded_core
    import hamming_pkg::*;
(
    input  logic [7:0] codeword,
    output logic [3:0] data,
    output logic [2:0] syndrome,
    output err_class_e err_class
);

    syndrome_t syn;
    logic      par;
    codeword_t fixed;

    // Classify the word and flip the bit the syndrome points at when exactly one bit is bad
    always_comb begin
        syn       = calc_syndrome(codeword);
        par       = calc_parity(codeword);
        fixed     = codeword;
        err_class = NONE;
        if (syn != 3'd0) begin
            if (par) begin
                fixed[syn - 3'd1] = ~codeword[syn - 3'd1];
                err_class         = CORRECTED;
            end else begin
                // Even parity with a nonzero syndrome: two flips, data left as received
                err_class = UNCORRECTABLE;
            end
        end else if (par) begin
            // Only the overall parity bit is wrong; the data bits are intact
            err_class = CORRECTED;
        end
        data     = extract_data(fixed);
        syndrome = syn;
    end

endmodule

// File: rtl/hamming_secded_rx.sv
// rtl/hamming_secded_rx.sv - two-stage SECDED receiver with handshake and error counters
module hamming_secded_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    input  logic             clr_counters,
    output logic [CNT_W-1:0] cnt_corrected,
    output logic [CNT_W-1:0] cnt_uncorrectable
);

    logic       s1_valid;
    codeword_t  s1_cw;
    syndrome_t  s1_syn;
    logic       s1_par;

    logic       s2_load;
    logic       s1_load;
    logic       out_fire;

    nibble_t    core_data;
    syndrome_t  core_syndrome;
    err_class_e core_class;

    // A stage may load when it is empty or its content leaves in this same cycle
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load && !rst;
    assign out_fire = out_valid && out_ready;

    hamming_secded_core u_core (
        .codeword  (s1_cw),
        .data      (core_data),
        .syndrome  (core_syndrome),
        .err_class (core_class)
    );

    // Stage 1: capture the accepted codeword together with its syndrome and overall parity
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= in_codeword;
                s1_syn <= calc_syndrome(in_codeword);
                s1_par <= calc_parity(in_codeword);
            end
        end
    end

    // Stage 2: register corrected data and flags; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data          <= core_data;
                out_syndrome      <= s1_syn;
                out_corrected     <= (core_class == CORRECTED);
                out_uncorrectable <= (core_class == UNCORRECTABLE);
            end
        end
    end

    // Captured syndrome/parity must agree with the core's own decode of the same word
    always_comb begin
        if (s1_valid) begin
            assert (core_syndrome == s1_syn && ((core_class == CORRECTED) == s1_par));
        end
    end

    // Saturating statistics counted on output transfers; clear takes priority
    always_ff @(posedge clk) begin
        if (rst || clr_counters) begin
            cnt_corrected     <= '0;
            cnt_uncorrectable <= '0;
        end else if (out_fire) begin
            if (out_corrected && cnt_corrected != '1) begin
                cnt_corrected <= cnt_corrected + 1'b1;
            end
            if (out_uncorrectable && cnt_uncorrectable != '1) begin
                cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_rx.sv
// tb/tb_hamming_secded_rx.sv - directed self-checking bench for hamming_secded_rx
module tb_hamming_secded_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_codeword;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic       out_corrected;
    logic       out_uncorrectable;
    logic       clr_counters;
    logic [3:0] cnt_corrected;
    logic [3:0] cnt_uncorrectable;

    int n_checks = 0;
    int n_pass   = 0;

    hamming_secded_rx #(.CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_codeword       (in_codeword),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .clr_counters      (clr_counters),
        .cnt_corrected     (cnt_corrected),
        .cnt_uncorrectable (cnt_uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_codeword = 8'h00; out_ready = 1'b0; clr_counters = 1'b0;
        repeat (3) step();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 4'h0 || out_syndrome !== 3'd0) $display("FAIL rst_data got %h/%h want 0/0", out_data, out_syndrome); else n_pass++;
        n_checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) $display("FAIL rst_flags got %b%b want 00", out_corrected, out_uncorrectable); else n_pass++;
        n_checks++; if (cnt_corrected !== 4'd0 || cnt_uncorrectable !== 4'd0) $display("FAIL rst_counters got %0d/%0d want 0/0", cnt_corrected, cnt_uncorrectable); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_clean();
        out_ready = 1'b1; in_valid = 1'b1; in_codeword = 8'h55;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL clean_in_ready got %b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL clean_early_valid got %b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL clean_valid got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 4'b1011) $display("FAIL clean_data got %b want 1011", out_data); else n_pass++;
        n_checks++; if (out_syndrome !== 3'b000) $display("FAIL clean_syn got %b want 000", out_syndrome); else n_pass++;
        n_checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) $display("FAIL clean_flags got %b%b want 00", out_corrected, out_uncorrectable); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL clean_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_single_error();
        in_valid = 1'b1; in_codeword = 8'h45;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (out_data !== 4'b1011) $display("FAIL single_data got %b want 1011", out_data); else n_pass++;
        n_checks++; if (out_syndrome !== 3'b101) $display("FAIL single_syn got %b want 101", out_syndrome); else n_pass++;
        n_checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) $display("FAIL single_flags got %b%b want 10", out_corrected, out_uncorrectable); else n_pass++;
        step();
        n_checks++; if (cnt_corrected !== 4'd1) $display("FAIL single_cnt got %0d want 1", cnt_corrected); else n_pass++;
    endtask

    task automatic test_double_error();
        in_valid = 1'b1; in_codeword = 8'h41;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (out_data !== 4'b1000) $display("FAIL double_data got %b want 1000", out_data); else n_pass++;
        n_checks++; if (out_syndrome !== 3'b110) $display("FAIL double_syn got %b want 110", out_syndrome); else n_pass++;
        n_checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b1) $display("FAIL double_flags got %b%b want 01", out_corrected, out_uncorrectable); else n_pass++;
        step();
        n_checks++; if (cnt_uncorrectable !== 4'd1 || cnt_corrected !== 4'd1) $display("FAIL double_cnt got %0d/%0d want 1/1", cnt_corrected, cnt_uncorrectable); else n_pass++;
    endtask

    task automatic test_parity_bit_error();
        in_valid = 1'b1; in_codeword = 8'hD5;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (out_data !== 4'b1011) $display("FAIL par_data got %b want 1011", out_data); else n_pass++;
        n_checks++; if (out_syndrome !== 3'b000) $display("FAIL par_syn got %b want 000", out_syndrome); else n_pass++;
        n_checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) $display("FAIL par_flags got %b%b want 10", out_corrected, out_uncorrectable); else n_pass++;
        step();
        n_checks++; if (cnt_corrected !== 4'd2) $display("FAIL par_cnt got %0d want 2", cnt_corrected); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        logic [3:0] exp   [4];
        words = '{8'h00, 8'h87, 8'h99, 8'hAA};
        exp   = '{4'h0, 4'h1, 4'h2, 4'h4};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== exp[c-2])
                    $display("FAIL b2b_out%0d got v=%b d=%h want v=1 d=%h", c-2, out_valid, out_data, exp[c-2]);
                else n_pass++;
            end
            in_valid = (c < 4);
            in_codeword = (c < 4) ? words[c] : 8'h00;
            #1;
            if (c < 4) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d got %b want 1", c, in_ready); else n_pass++;
            end
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_codeword = 8'h4B;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_accept0 got %b want 1", in_ready); else n_pass++;
        step();
        in_codeword = 8'h99;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_accept1 got %b want 1", in_ready); else n_pass++;
        step();
        in_codeword = 8'hAA;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h8) $display("FAIL bp_head got v=%b d=%h want v=1 d=8", out_valid, out_data); else n_pass++;
        step();
        n_checks++; if (out_data !== 4'h8 || in_ready !== 1'b0) $display("FAIL bp_hold got d=%h r=%b want d=8 r=0", out_data, in_ready); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h2) $display("FAIL bp_second got v=%b d=%h want v=1 d=2", out_valid, out_data); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h4) $display("FAIL bp_third got v=%b d=%h want v=1 d=4", out_valid, out_data); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        logic [7:0]  words [10];
        logic [3:0]  exp_d [10];
        logic [2:0]  exp_s [10];
        logic [31:0] pat;
        int          tx;
        int          rx;
        logic        prev_stall;
        logic [3:0]  prev_data;
        logic [2:0]  prev_syn;
        words = '{8'h00, 8'h87, 8'h99, 8'hAA, 8'h4B, 8'hFF, 8'h1E, 8'h2D, 8'h37, 8'h45};
        exp_d = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h3, 4'h5, 4'h6, 4'hB};
        exp_s = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5};
        pat = 32'hB53C_96E1;
        tx = 0; rx = 0; prev_stall = 1'b0; prev_data = '0; prev_syn = '0;
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_syndrome !== prev_syn)
                    $display("FAIL stream_stable got v=%b d=%h s=%h want v=1 d=%h s=%h", out_valid, out_data, out_syndrome, prev_data, prev_syn);
                else n_pass++;
            end
            out_ready   = pat[cyc % 32];
            in_valid    = (tx < 10);
            in_codeword = (tx < 10) ? words[tx] : 8'h00;
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== exp_d[rx] || out_syndrome !== exp_s[rx])
                    $display("FAIL stream_word%0d got d=%h s=%h want d=%h s=%h", rx, out_data, out_syndrome, exp_d[rx], exp_s[rx]);
                else n_pass++;
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_syn   = out_syndrome;
            if (in_valid && in_ready) tx++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (rx !== 10) $display("FAIL stream_count got %0d want 10", rx); else n_pass++;
        repeat (2) step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_extra got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_counters();
        n_checks++; if (cnt_corrected !== 4'd4 || cnt_uncorrectable !== 4'd1) $display("FAIL cnt_accum got %0d/%0d want 4/1", cnt_corrected, cnt_uncorrectable); else n_pass++;
        clr_counters = 1'b1;
        step();
        clr_counters = 1'b0;
        n_checks++; if (cnt_corrected !== 4'd0 || cnt_uncorrectable !== 4'd0) $display("FAIL cnt_clear got %0d/%0d want 0/0", cnt_corrected, cnt_uncorrectable); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_codeword = 8'h45;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        n_checks++; if (cnt_corrected !== 4'hF) $display("FAIL cnt_saturate got %0d want 15", cnt_corrected); else n_pass++;
        n_checks++; if (cnt_uncorrectable !== 4'd0) $display("FAIL cnt_unc_idle got %0d want 0", cnt_uncorrectable); else n_pass++;
        in_valid = 1'b1; in_codeword = 8'h45;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_corrected !== 1'b1) $display("FAIL cnt_pending got v=%b c=%b want 1/1", out_valid, out_corrected); else n_pass++;
        clr_counters = 1'b1;
        step();
        clr_counters = 1'b0;
        n_checks++; if (cnt_corrected !== 4'd0) $display("FAIL cnt_clear_wins got %0d want 0", cnt_corrected); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL cnt_clear_xfer got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1; in_codeword = 8'h4B;
        step();
        in_codeword = 8'h99;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_loaded got %b want 1", out_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", in_ready); else n_pass++;
        step();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_ghost%0d got %b want 0", i, out_valid); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_double_error();
        test_parity_bit_error();
        test_back_to_back();
        test_backpressure();
        test_stream();
        test_counters();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
